// File: rtl/seg_limit_check_pipe_if.sv
`default_nettype none
// ============================================================================
// Module      : seg_limit_check_pipe_if
// Description : Access, control and syndrome bundle for the segment-limit
//               checker. The master side presents accesses, limit writes and
//               pipeline control, and observes the per-access fault result
//               and the sticky syndrome.
// Revision    : 1.0 - initial release
// ============================================================================
interface seg_limit_check_pipe_if #(
    parameter int ADDR_W   = 32,
    parameter int LIMIT_W  = 20,
    parameter int SEG_ID_W = 3
);
    // Access presented to stage 1
    logic                in_v;
    logic                mem_rd;
    logic                mem_wr;
    logic [SEG_ID_W-1:0] seg_id;
    logic [1:0]          data_size;
    logic [ADDR_W-1:0]   add_base_disp;
    logic [ADDR_W-1:0]   mux_sib_si;

    // Pipeline control
    logic                stall;
    logic                flush;

    // Limit register file write port
    logic                lim_we;
    logic [SEG_ID_W-1:0] lim_wseg;
    logic [LIMIT_W-1:0]  lim_wdata;

    // Syndrome clear
    logic                exc_clr;

    // Results
    logic                out_v;
    logic                exc;
    logic                exc_pend;
    logic [ADDR_W-1:0]   exc_addr;
    logic [SEG_ID_W-1:0] exc_seg;

    modport master (
        output in_v, mem_rd, mem_wr, seg_id, data_size, add_base_disp, mux_sib_si,
        output stall, flush, lim_we, lim_wseg, lim_wdata, exc_clr,
        input  out_v, exc, exc_pend, exc_addr, exc_seg
    );

    modport slave (
        input  in_v, mem_rd, mem_wr, seg_id, data_size, add_base_disp, mux_sib_si,
        input  stall, flush, lim_we, lim_wseg, lim_wdata, exc_clr,
        output out_v, exc, exc_pend, exc_addr, exc_seg
    );
endinterface
`default_nettype wire

// File: rtl/seg_limit_check_pipe.sv
`default_nettype none
// ============================================================================
// Module      : seg_limit_check_pipe
// Description : Two-stage segment-limit checker. Stage 1 forms the effective
//               address and the size-adjusted limit; stage 2 compares them and
//               reports a fault. The first fault is held in a sticky syndrome
//               until cleared.
// Revision    : 1.0 - initial release
// ============================================================================
module seg_limit_check_pipe #(
    parameter int                         ADDR_W     = 32,
    parameter int                         LIMIT_W    = 20,
    parameter int                         NUM_SEG    = 6,
    parameter int                         SEG_ID_W   = 3,
    parameter logic [NUM_SEG-1:0]         CHECK_MASK = 6'b111011,
    parameter logic [NUM_SEG*LIMIT_W-1:0] LIMIT_RST  = {20'h007FF, 20'h003FF, 20'h011FF,
                                                        20'h04000, 20'h04FFF, 20'h003FF}
) (
    input wire                   clk,
    input wire                   rst,
    seg_limit_check_pipe_if.slave bus
);

    // Adjusted limit carries one extra bit so that limit < size-1 shows up
    // as a negative value instead of wrapping to a huge positive limit.
    localparam int c_adj_w = ADDR_W + 1;

    // ------------------------------------------------------------------------
    // Limit register file (one register per segment, flattened for lookup)
    // ------------------------------------------------------------------------
    logic [NUM_SEG*LIMIT_W-1:0] w_limits;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SEG; gi++) begin : g_seg_limit
            logic [LIMIT_W-1:0] r_lim;
            logic               w_hit;

            assign w_hit = bus.lim_we && (bus.lim_wseg == SEG_ID_W'(gi));

            // Segment limit: reset value, then software writes regardless of pipeline state
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_lim <= LIMIT_RST[gi*LIMIT_W +: LIMIT_W];
                end else if (w_hit) begin
                    r_lim <= bus.lim_wdata;
                end
            end

            assign w_limits[gi*LIMIT_W +: LIMIT_W] = r_lim;
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Stage 1 combinational: effective address, limit select, size adjust
    // ------------------------------------------------------------------------
    logic [ADDR_W-1:0]  w_ea;
    logic               w_v_in;
    logic [LIMIT_W-1:0] w_lim_sel;
    logic               w_chk;
    logic [c_adj_w-1:0] w_size_m1;
    logic [c_adj_w-1:0] w_lim_adj;

    // Carry out of the address add is intentionally dropped
    assign w_ea   = bus.add_base_disp + bus.mux_sib_si;
    assign w_v_in = bus.in_v & (bus.mem_rd | bus.mem_wr);

    // Select the segment's limit and check enable; out-of-range IDs stay unchecked.
    // A same-cycle write to the accessed segment is forwarded.
    always_comb begin
        w_lim_sel = '0;
        w_chk     = 1'b0;
        for (int i = 0; i < NUM_SEG; i++) begin
            if (bus.seg_id == SEG_ID_W'(i)) begin
                w_lim_sel = w_limits[i*LIMIT_W +: LIMIT_W];
                w_chk     = CHECK_MASK[i];
            end
        end
        if (bus.lim_we && (bus.lim_wseg == bus.seg_id)) begin
            w_lim_sel = bus.lim_wdata;
        end
    end

    // Access size minus one: 0, 1, 3 or 7 bytes past the first byte
    always_comb begin
        w_size_m1 = '0;
        case (bus.data_size)
            2'd0:    w_size_m1 = c_adj_w'(0);
            2'd1:    w_size_m1 = c_adj_w'(1);
            2'd2:    w_size_m1 = c_adj_w'(3);
            default: w_size_m1 = c_adj_w'(7);
        endcase
    end

    assign w_lim_adj = {{(c_adj_w-LIMIT_W){1'b0}}, w_lim_sel} - w_size_m1;

    // ------------------------------------------------------------------------
    // Pipeline registers
    // ------------------------------------------------------------------------
    logic                r_v1;
    logic                r_chk1;
    logic [ADDR_W-1:0]   r_ea1;
    logic [SEG_ID_W-1:0] r_seg1;
    logic [c_adj_w-1:0]  r_lim_adj1;

    logic                r_out_v;
    logic                r_exc;
    logic                r_exc_pend;
    logic [ADDR_W-1:0]   r_exc_addr;
    logic [SEG_ID_W-1:0] r_exc_seg;

    // ------------------------------------------------------------------------
    // Stage 2 combinational: compare and syndrome capture decision
    // ------------------------------------------------------------------------
    logic w_over;
    logic w_exc2;
    logic w_capture;

    // Last byte beyond limit: either the adjusted limit went negative or EA exceeds it
    assign w_over    = r_lim_adj1[ADDR_W] | (r_ea1 > r_lim_adj1[ADDR_W-1:0]);
    assign w_exc2    = r_v1 & r_chk1 & w_over;
    // A clear on the same edge as a new fault lets the new fault take the syndrome
    assign w_capture = w_exc2 & (~r_exc_pend | bus.exc_clr);

    // Pipeline advance with reset > flush > stall priority, plus sticky syndrome
    always_ff @(posedge clk) begin
        if (rst) begin
            r_v1       <= 1'b0;
            r_chk1     <= 1'b0;
            r_ea1      <= '0;
            r_seg1     <= '0;
            r_lim_adj1 <= '0;
            r_out_v    <= 1'b0;
            r_exc      <= 1'b0;
            r_exc_pend <= 1'b0;
            r_exc_addr <= '0;
            r_exc_seg  <= '0;
        end else if (bus.flush) begin
            r_v1    <= 1'b0;
            r_out_v <= 1'b0;
            r_exc   <= 1'b0;
            if (bus.exc_clr) begin
                r_exc_pend <= 1'b0;
            end
        end else if (bus.stall) begin
            // Held entry is not recaptured; only the clear acts
            if (bus.exc_clr) begin
                r_exc_pend <= 1'b0;
            end
        end else begin
            r_v1       <= w_v_in;
            r_chk1     <= w_chk;
            r_ea1      <= w_ea;
            r_seg1     <= bus.seg_id;
            r_lim_adj1 <= w_lim_adj;
            r_out_v    <= r_v1;
            r_exc      <= w_exc2;
            if (w_capture) begin
                r_exc_pend <= 1'b1;
                r_exc_addr <= r_ea1;
                r_exc_seg  <= r_seg1;
            end else if (bus.exc_clr) begin
                r_exc_pend <= 1'b0;
            end
        end
    end

    assign bus.out_v    = r_out_v;
    assign bus.exc      = r_exc;
    assign bus.exc_pend = r_exc_pend;
    assign bus.exc_addr = r_exc_addr;
    assign bus.exc_seg  = r_exc_seg;

endmodule
`default_nettype wire

// File: tb/tb_seg_limit_check_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg_limit_check_pipe
// Description : Self-checking bench for seg_limit_check_pipe with directed
//               scenarios and a randomized run against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg_limit_check_pipe;
    localparam int ADDR_W   = 32;
    localparam int LIMIT_W  = 20;
    localparam int NUM_SEG  = 6;
    localparam int SEG_ID_W = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    seg_limit_check_pipe_if #(.ADDR_W(ADDR_W), .LIMIT_W(LIMIT_W), .SEG_ID_W(SEG_ID_W)) bus ();

    seg_limit_check_pipe #(
        .ADDR_W(ADDR_W), .LIMIT_W(LIMIT_W), .NUM_SEG(NUM_SEG), .SEG_ID_W(SEG_ID_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int total = 0;
    int bad   = 0;

    // Behavioural model state
    longint     c_rst_lim [NUM_SEG] = '{64'h3FF, 64'h4FFF, 64'h4000, 64'h11FF, 64'h3FF, 64'h7FF};
    bit         c_mask    [NUM_SEG] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    longint     m_lim     [NUM_SEG];
    bit         m_s1_v, m_s1_f;
    logic [31:0] m_s1_ea;
    logic [2:0]  m_s1_seg;
    bit         m_out_v, m_exc, m_pend;
    logic [31:0] m_addr;
    logic [2:0]  m_seg;

    task automatic idle();
        bus.in_v = 1'b0; bus.mem_rd = 1'b0; bus.mem_wr = 1'b0; bus.seg_id = '0;
        bus.data_size = '0; bus.add_base_disp = '0; bus.mux_sib_si = '0;
        bus.stall = 1'b0; bus.flush = 1'b0; bus.lim_we = 1'b0; bus.lim_wseg = '0;
        bus.lim_wdata = '0; bus.exc_clr = 1'b0;
    endtask

    task automatic access(input logic [2:0] seg, input logic [1:0] size,
                          input logic [31:0] base, input logic [31:0] idx);
        bus.in_v = 1'b1; bus.mem_rd = 1'b1; bus.mem_wr = 1'b0; bus.seg_id = seg;
        bus.data_size = size; bus.add_base_disp = base; bus.mux_sib_si = idx;
    endtask

    // Advance one clock; the model judges each access by "last byte > limit"
    task automatic step();
        longint ea, lim_eff;
        bit     fault, v_in, new_exc;
        int     sg;
        @(posedge clk);
        sg      = int'(bus.seg_id);
        ea      = (longint'(bus.add_base_disp) + longint'(bus.mux_sib_si)) & 64'hFFFF_FFFF;
        v_in    = bus.in_v && (bus.mem_rd || bus.mem_wr);
        fault   = 1'b0;
        lim_eff = 0;
        if (v_in && sg < NUM_SEG) begin
            if (c_mask[sg]) begin
                lim_eff = (bus.lim_we && bus.lim_wseg == bus.seg_id) ? longint'(bus.lim_wdata) : m_lim[sg];
                fault   = (ea + (longint'(1) << bus.data_size) - 1) > lim_eff;
            end
        end
        if (rst) begin
            for (int i = 0; i < NUM_SEG; i++) m_lim[i] = c_rst_lim[i];
            m_s1_v = 0; m_s1_f = 0; m_out_v = 0; m_exc = 0; m_pend = 0; m_addr = '0; m_seg = '0;
        end else begin
            if (bus.flush) begin
                m_s1_v = 0; m_out_v = 0; m_exc = 0;
                if (bus.exc_clr) m_pend = 0;
            end else if (bus.stall) begin
                if (bus.exc_clr) m_pend = 0;
            end else begin
                new_exc = m_s1_v && m_s1_f;
                if (new_exc && (!m_pend || bus.exc_clr)) begin
                    m_pend = 1; m_addr = m_s1_ea; m_seg = m_s1_seg;
                end else if (bus.exc_clr) begin
                    m_pend = 0;
                end
                m_out_v = m_s1_v; m_exc = new_exc;
                m_s1_v = v_in; m_s1_f = fault; m_s1_ea = ea[31:0]; m_s1_seg = bus.seg_id;
            end
            if (bus.lim_we && int'(bus.lim_wseg) < NUM_SEG) m_lim[int'(bus.lim_wseg)] = longint'(bus.lim_wdata);
        end
        #1;
    endtask

    task automatic drain_and_clear();
        idle(); step(); step();
        bus.exc_clr = 1'b1; step(); idle();
    endtask

    task automatic test_reset();
        rst = 1'b1; idle(); step(); step();
        total++; if (bus.out_v !== 1'b0) begin bad++; $display("FAIL reset_out_v: got %0b want 0", bus.out_v); end
        total++; if (bus.exc !== 1'b0) begin bad++; $display("FAIL reset_exc: got %0b want 0", bus.exc); end
        total++; if (bus.exc_pend !== 1'b0) begin bad++; $display("FAIL reset_pend: got %0b want 0", bus.exc_pend); end
        total++; if (bus.exc_addr !== 32'h0) begin bad++; $display("FAIL reset_addr: got %0h want 0", bus.exc_addr); end
        total++; if (bus.exc_seg !== 3'd0) begin bad++; $display("FAIL reset_seg: got %0d want 0", bus.exc_seg); end
        rst = 1'b0;
    endtask

    task automatic test_ds_boundary();
        access(3'd3, 2'd2, 32'h11FC, 32'h0); step();
        access(3'd3, 2'd2, 32'h11FD, 32'h0); step();
        total++; if (bus.out_v !== 1'b1 || bus.exc !== 1'b0) begin bad++; $display("FAIL ds_fit: got v=%0b exc=%0b want v=1 exc=0", bus.out_v, bus.exc); end
        idle(); step();
        total++; if (bus.out_v !== 1'b1 || bus.exc !== 1'b1) begin bad++; $display("FAIL ds_over: got v=%0b exc=%0b want v=1 exc=1", bus.out_v, bus.exc); end
        total++; if (bus.exc_pend !== 1'b1) begin bad++; $display("FAIL ds_pend: got %0b want 1", bus.exc_pend); end
        total++; if (bus.exc_addr !== 32'h11FD || bus.exc_seg !== 3'd3) begin bad++; $display("FAIL ds_syndrome: got addr=%0h seg=%0d want addr=11fd seg=3", bus.exc_addr, bus.exc_seg); end
    endtask

    task automatic test_unchecked();
        drain_and_clear();
        access(3'd2, 2'd3, 32'hFFFF_FFF0, 32'h0); step();
        access(3'd6, 2'd3, 32'hFFFF_0000, 32'h0); step();
        total++; if (bus.out_v !== 1'b1 || bus.exc !== 1'b0) begin bad++; $display("FAIL ss_unchecked: got v=%0b exc=%0b want v=1 exc=0", bus.out_v, bus.exc); end
        access(3'd0, 2'd3, 32'h0010_0000, 32'h0); bus.mem_rd = 1'b0; step();
        total++; if (bus.out_v !== 1'b1 || bus.exc !== 1'b0) begin bad++; $display("FAIL seg6_unchecked: got v=%0b exc=%0b want v=1 exc=0", bus.out_v, bus.exc); end
        idle(); step();
        total++; if (bus.out_v !== 1'b0) begin bad++; $display("FAIL no_mem_op: got v=%0b want 0", bus.out_v); end
        total++; if (bus.exc_pend !== 1'b0) begin bad++; $display("FAIL unchecked_pend: got %0b want 0", bus.exc_pend); end
    endtask

    task automatic test_bypass();
        drain_and_clear();
        access(3'd0, 2'd2, 32'h0, 32'h0);
        bus.lim_we = 1'b1; bus.lim_wseg = 3'd0; bus.lim_wdata = 20'h2; step();
        bus.lim_we = 1'b0; access(3'd0, 2'd0, 32'h0, 32'h0); step();
        total++; if (bus.exc !== 1'b1) begin bad++; $display("FAIL bypass_neg: got exc=%0b want 1", bus.exc); end
        idle(); step();
        total++; if (bus.out_v !== 1'b1 || bus.exc !== 1'b0) begin bad++; $display("FAIL bypass_1b: got v=%0b exc=%0b want v=1 exc=0", bus.out_v, bus.exc); end
        total++; if (bus.exc_pend !== 1'b1 || bus.exc_seg !== 3'd0 || bus.exc_addr !== 32'h0) begin bad++; $display("FAIL bypass_syn: got pend=%0b seg=%0d addr=%0h want 1/0/0", bus.exc_pend, bus.exc_seg, bus.exc_addr); end
    endtask

    task automatic test_back_to_back();
        drain_and_clear();
        access(3'd5, 2'd0, 32'h800, 32'h0); step();
        access(3'd4, 2'd0, 32'h400, 32'h0); step();
        total++; if (bus.exc !== 1'b1 || bus.exc_addr !== 32'h800 || bus.exc_seg !== 3'd5) begin bad++; $display("FAIL b2b_first: got exc=%0b addr=%0h seg=%0d want 1/800/5", bus.exc, bus.exc_addr, bus.exc_seg); end
        idle(); step();
        total++; if (bus.exc !== 1'b1 || bus.exc_addr !== 32'h800) begin bad++; $display("FAIL b2b_sticky: got exc=%0b addr=%0h want 1/800", bus.exc, bus.exc_addr); end
        step();
        access(3'd5, 2'd0, 32'h800, 32'h0); step();
        access(3'd4, 2'd0, 32'h400, 32'h0); step();
        idle(); bus.exc_clr = 1'b1; step(); idle();
        total++; if (bus.exc_pend !== 1'b1 || bus.exc_addr !== 32'h400 || bus.exc_seg !== 3'd4) begin bad++; $display("FAIL clr_vs_capture: got pend=%0b addr=%0h seg=%0d want 1/400/4", bus.exc_pend, bus.exc_addr, bus.exc_seg); end
    endtask

    task automatic test_stall();
        drain_and_clear();
        access(3'd3, 2'd0, 32'h2000, 32'h0); step();
        idle(); step();
        total++; if (bus.exc !== 1'b1 || bus.exc_addr !== 32'h2000) begin bad++; $display("FAIL stall_pre: got exc=%0b addr=%0h want 1/2000", bus.exc, bus.exc_addr); end
        for (int c = 0; c < 3; c++) begin
            access(3'd3, 2'd0, 32'h3000, 32'h0); bus.stall = 1'b1; bus.exc_clr = (c == 1);
            step();
            total++; if (bus.out_v !== 1'b1 || bus.exc !== 1'b1) begin bad++; $display("FAIL stall_hold%0d: got v=%0b exc=%0b want 1/1", c, bus.out_v, bus.exc); end
            total++; if (bus.exc_pend !== (c == 0)) begin bad++; $display("FAIL stall_pend%0d: got %0b want %0b", c, bus.exc_pend, (c == 0)); end
        end
        idle(); bus.stall = 1'b1; bus.flush = 1'b1; step();
        total++; if (bus.out_v !== 1'b0 || bus.exc !== 1'b0) begin bad++; $display("FAIL flush_in_stall: got v=%0b exc=%0b want 0/0", bus.out_v, bus.exc); end
        idle(); step();
        total++; if (bus.out_v !== 1'b0) begin bad++; $display("FAIL flush_s1: got v=%0b want 0", bus.out_v); end
    endtask

    task automatic test_wrap();
        access(3'd1, 2'd0, 32'hFFFF_FFFF, 32'h2); step();
        idle(); step();
        total++; if (bus.out_v !== 1'b1 || bus.exc !== 1'b0) begin bad++; $display("FAIL ea_wrap: got v=%0b exc=%0b want 1/0", bus.out_v, bus.exc); end
    endtask

    task automatic test_rst_inflight();
        idle(); bus.lim_we = 1'b1; bus.lim_wseg = 3'd3; bus.lim_wdata = 20'h10; step();
        access(3'd3, 2'd0, 32'h100, 32'h0); step();
        access(3'd3, 2'd0, 32'h200, 32'h0); step();
        idle(); rst = 1'b1; step(); rst = 1'b0;
        total++; if (bus.out_v !== 1'b0 || bus.exc !== 1'b0 || bus.exc_pend !== 1'b0) begin bad++; $display("FAIL rst_flight: got v=%0b exc=%0b pend=%0b want 0/0/0", bus.out_v, bus.exc, bus.exc_pend); end
        access(3'd3, 2'd2, 32'h11FC, 32'h0); step();
        access(3'd0, 2'd2, 32'h3FD, 32'h0); step();
        total++; if (bus.out_v !== 1'b1 || bus.exc !== 1'b0) begin bad++; $display("FAIL rst_ds_lim: got v=%0b exc=%0b want 1/0", bus.out_v, bus.exc); end
        idle(); step();
        total++; if (bus.exc !== 1'b1) begin bad++; $display("FAIL rst_es_lim: got exc=%0b want 1", bus.exc); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            bus.in_v          = ($urandom_range(0, 9) != 0);
            bus.mem_rd        = 1'($urandom_range(0, 1));
            bus.mem_wr        = ($urandom_range(0, 3) == 0);
            bus.seg_id        = 3'($urandom_range(0, 7));
            bus.data_size     = 2'($urandom_range(0, 3));
            bus.add_base_disp = ($urandom_range(0, 3) == 0) ? 32'($urandom) : 32'($urandom_range(0, 'h5000));
            bus.mux_sib_si    = ($urandom_range(0, 1) == 0) ? 32'h0 : 32'($urandom_range(0, 16));
            bus.stall         = ($urandom_range(0, 9) == 0);
            bus.flush         = ($urandom_range(0, 19) == 0);
            bus.lim_we        = ($urandom_range(0, 6) == 0);
            bus.lim_wseg      = 3'($urandom_range(0, 7));
            bus.lim_wdata     = 20'($urandom_range(0, 'h5000));
            bus.exc_clr       = ($urandom_range(0, 7) == 0);
            step();
            total++; if (bus.out_v !== m_out_v) begin bad++; $display("FAIL rnd_out_v@%0d: got %0b want %0b", n, bus.out_v, m_out_v); end
            total++; if (bus.exc !== m_exc) begin bad++; $display("FAIL rnd_exc@%0d: got %0b want %0b", n, bus.exc, m_exc); end
            total++; if (bus.exc_pend !== m_pend) begin bad++; $display("FAIL rnd_pend@%0d: got %0b want %0b", n, bus.exc_pend, m_pend); end
            total++; if (bus.exc_addr !== m_addr) begin bad++; $display("FAIL rnd_addr@%0d: got %0h want %0h", n, bus.exc_addr, m_addr); end
            total++; if (bus.exc_seg !== m_seg) begin bad++; $display("FAIL rnd_seg@%0d: got %0d want %0d", n, bus.exc_seg, m_seg); end
        end
        idle();
    endtask

    initial begin
        rst = 1'b1;
        idle();
        test_reset();
        test_ds_boundary();
        test_unchecked();
        test_bypass();
        test_back_to_back();
        test_stall();
        test_wrap();
        test_rst_inflight();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/seg_limit_check_pipe.md
# seg_limit_check_pipe

Pipelined, parametrised segment-limit checker for the address-generation stage of the memory pipeline. Each cycle it accepts one memory access (base+displacement, scaled index, segment ID, access size), checks that the last byte of the access lies within the selected segment's limit, and reports a per-access fault two cycles later. Segment limits live in a writable register file, and the first fault is captured in sticky syndrome registers until software or the exception unit clears it.

## Interface
Parameters:
- ADDR_W, 32, effective-address width
- LIMIT_W, 20, limit register width (zero-extended to ADDR_W)
- NUM_SEG, 6, segment count; IDs 0..NUM_SEG-1 (ES=0, CS=1, SS=2, DS=3, FS=4, GS=5)
- SEG_ID_W, 3, segment ID width
- CHECK_MASK, 6'b111011, bit i=1 enables checking of segment i (SS unchecked)
- LIMIT_RST, {GS 0x007FF, FS 0x003FF, DS 0x011FF, SS 0x04000, CS 0x04FFF, ES 0x003FF}, packed per-segment reset limits

Ports:
- CLK  in  1  clock
- RST  in  1  synchronous, active-high reset
- IN_V  in  1  access valid
- MEM_RD, MEM_WR  in  1 each  access reads/writes memory; checked only if either is set
- SEG_ID  in  SEG_ID_W  segment of access
- DATA_SIZE  in  2  0=1B, 1=2B, 2=4B, 3=8B
- ADD_BASE_DISP  in  ADDR_W  base+displacement
- MUX_SIB_SI  in  ADDR_W  scaled index (0 if none)
- STALL  in  1  hold both stages
- FLUSH  in  1  kill both stages
- LIM_WE  in  1  limit write enable
- LIM_WSEG  in  SEG_ID_W  limit write target
- LIM_WDATA  in  LIMIT_W  new limit
- EXC_CLR  in  1  clear sticky syndrome
- OUT_V  out  1  stage-2 entry valid
- EXC  out  1  stage-2 entry faults (qualified by OUT_V)
- EXC_PEND  out  1  sticky: a fault has been captured
- EXC_ADDR  out  ADDR_W  effective address of the captured fault
- EXC_SEG  out  SEG_ID_W  segment of the captured fault

## Operation
- EA = (ADD_BASE_DISP + MUX_SIB_SI) mod 2^ADDR_W; carry out is ignored.
- Stage 1 registers: v1 = IN_V & (MEM_RD|MEM_WR), EA, SEG_ID, chk1, and lim_adj = {0,limit} - (2^DATA_SIZE - 1) computed in ADDR_W+1 bits.
- chk1 = 1 only if SEG_ID < NUM_SEG and CHECK_MASK[SEG_ID] = 1; IDs >= NUM_SEG never fault.
- Stage 2: EXC = v1 & chk1 & (lim_adj negative OR EA > lim_adj[ADDR_W-1:0]), unsigned. A negative lim_adj (limit < size-1) always faults.
- Fault condition is equivalent to EA + size - 1 > limit, with no modular wrap of the limit side.
- Limit write: LIMIT[LIM_WSEG] <= LIM_WDATA at the edge. Writes to IDs >= NUM_SEG are ignored. Writes proceed regardless of STALL or FLUSH.
- Write bypass: if LIM_WE and LIM_WSEG == SEG_ID in the cycle stage 1 samples, stage 1 uses LIM_WDATA.
- Syndrome: on an edge where stage 2 loads an entry with EXC=1 and EXC_PEND=0, the block sets EXC_PEND and captures EXC_ADDR/EXC_SEG. Later faults do not overwrite the syndrome.
- EXC_CLR clears EXC_PEND. If a new fault loads on the same edge, capture wins: EXC_PEND stays 1 and the new syndrome is captured.

## Timing
- Latency 2: an access presented before edge k appears on OUT_V/EXC after edge k+1. Throughput is 1 per cycle.
- Priority: RST > FLUSH > STALL > normal.
- RST: all outputs 0 (OUT_V, EXC, EXC_PEND, EXC_ADDR, EXC_SEG), v1=0, limits = LIMIT_RST.
- STALL=1: stage-1 and stage-2 registers hold, inputs are ignored, and no syndrome capture occurs (a held faulting entry is not recaptured). Limit writes and EXC_CLR still take effect.
- FLUSH=1: v1 and OUT_V clear at the edge, EXC clears, and inputs that cycle are dropped. Syndrome is unaffected.
- RST mid-operation discards in-flight entries. Limits revert to reset values.

## Test plan
- Reset then DS access EA=0x11FC, size 4 -> OUT_V=1, EXC=0 two cycles later. EA=0x11FD, size 4 -> EXC=1, EXC_PEND=1, EXC_ADDR=0x11FD, EXC_SEG=3.
- SS access EA=0xFFFFFFF0, size 8 -> EXC=0. Access with SEG_ID=6 -> EXC=0. MEM_RD=MEM_WR=0 with an out-of-range ES access -> OUT_V=0.
- Write ES limit=0x2 and issue ES access EA=0, size 4 in the same cycle -> bypass used, lim_adj negative, EXC=1. Next access EA=0, size 1 -> EXC=0.
- Back-to-back faults at GS 0x800 then FS 0x400 -> EXC_ADDR stays 0x800. EXC_CLR on the same edge the FS fault loads -> EXC_PEND=1, EXC_ADDR=0x400.
- Faulting access followed by STALL for 3 cycles -> OUT_V/EXC held, captured once. FLUSH during stall -> OUT_V=0 next cycle.
- Wide config ADDR_W=32, CS access base=0xFFFFFFFF, index=2 -> EA=1, EXC=0 (carry ignored). RST asserted with two entries in flight -> OUT_V=0 and limits back to reset values.
